// File: rtl/cnn_fp_pkg.sv
// rtl/cnn_fp_pkg.sv - shared IEEE-754 single-precision field constants and unpool FSM states
package cnn_fp_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Field positions inside a 32-bit float word
  localparam int SIGN_BIT = FP_W - 1;
  localparam int EXP_HI   = FP_W - 2;
  localparam int EXP_LO   = MAN_W;
  localparam int MAN_HI   = MAN_W - 1;
  localparam int MAN_LO   = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } unpool_state_t;

endpackage

// File: rtl/fp_quarter.sv
// rtl/fp_quarter.sv - combinational divide-by-4 of an IEEE-754 single (flush-to-zero)
//
// Ports:
//   x : input  float word
//   y : output x/4; Inf/NaN pass through, results that would be denormal
//       (or denormal/zero inputs) become a zero carrying the input sign
module fp_quarter
  import cnn_fp_pkg::*;
(
  input  logic [FP_W-1:0] x,
  output logic [FP_W-1:0] y
);

  logic             sgn;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sgn   = x[SIGN_BIT];
  assign exp_f = x[EXP_HI:EXP_LO];
  assign man_f = x[MAN_HI:MAN_LO];

  always_comb begin
    y = x;
    if (exp_f == EXP_MAX) begin
      y = x;
    end else if (exp_f >= 8'd3) begin
      // Dividing by 4 is an exponent decrement of 2 while the result stays normal
      y = {sgn, exp_f - 8'd2, man_f};
    end else begin
      y = {sgn, {(FP_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/avg_unpool_3d.sv
// rtl/avg_unpool_3d.sv - 2x2 average-unpooling (backward of avg pool) over Felements maps
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a frame (sampled only while idle)
//   ImagesIn   : pooled maps [Felements][Out_elements/2][Out_elements/2], captured on accepted start
//   ImagesOut  : upsampled maps [Felements][Out_elements][Out_elements]
//   valid      : one-cycle pulse when the frame's last pixel is written
//   busy       : high while the raster scan is running
module avg_unpool_3d
  import cnn_fp_pkg::*;
#(
  parameter int Felements    = 3,
  parameter int Out_elements = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [FP_W-1:0] ImagesIn  [Felements][Out_elements/2][Out_elements/2],
  output logic [FP_W-1:0] ImagesOut [Felements][Out_elements][Out_elements],
  output logic            valid,
  output logic            busy
);

  localparam int IN_N = Out_elements / 2;
  localparam int CW   = $clog2(Out_elements);
  localparam int IW   = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(Out_elements - 1);

  unpool_state_t state, state_next;

  logic [CW-1:0]   row, col;
  logic [IW-1:0]   row_in, col_in;
  logic            last;
  logic [FP_W-1:0] img_buf [Felements][IN_N][IN_N];
  logic [FP_W-1:0] q_in    [Felements];
  logic [FP_W-1:0] q_out   [Felements];

  // Each 2x2 output window maps back to one pooled pixel
  assign row_in = IW'(row >> 1);
  assign col_in = IW'(col >> 1);
  assign last   = (row == LAST_IDX) && (col == LAST_IDX);
  assign busy   = (state == RUN);

  for (genvar f = 0; f < Felements; f++) begin : g_quarter
    assign q_in[f] = img_buf[f][row_in][col_in];
    fp_quarter u_quarter (
      .x (q_in[f]),
      .y (q_out[f])
    );
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      valid <= 1'b0;
      for (int f = 0; f < Felements; f++) begin
        for (int r = 0; r < IN_N; r++)
          for (int c = 0; c < IN_N; c++)
            img_buf[f][r][c] <= '0;
        for (int r = 0; r < Out_elements; r++)
          for (int c = 0; c < Out_elements; c++)
            ImagesOut[f][r][c] <= '0;
      end
    end else begin
      state <= state_next;
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            img_buf <= ImagesIn;
            row     <= '0;
            col     <= '0;
          end
        end
        RUN: begin
          for (int f = 0; f < Felements; f++)
            ImagesOut[f][row][col] <= q_out[f];
          if (last) begin
            valid <= 1'b1;
            row   <= '0;
            col   <= '0;
          end else if (col == LAST_IDX) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avg_unpool_3d.sv
// tb/tb_avg_unpool_3d.sv - directed self-checking bench for avg_unpool_3d
module tb_avg_unpool_3d;

  logic        clk;
  logic        rst_n;

  // Small instance: N=4, F=1
  logic        start_a;
  logic [31:0] ins_a  [1][2][2];
  logic [31:0] out_a  [1][4][4];
  logic        valid_a, busy_a;

  // Default-size instance: N=10, F=3
  logic        start_b;
  logic [31:0] ins_b  [3][5][5];
  logic [31:0] ref_b  [3][5][5];
  logic [31:0] out_b  [3][10][10];
  logic        valid_b, busy_b;

  int n_checks;
  int n_fail;
  int n;

  avg_unpool_3d #(.Felements(1), .Out_elements(4)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .ImagesIn  (ins_a),
    .ImagesOut (out_a),
    .valid     (valid_a),
    .busy      (busy_a)
  );

  avg_unpool_3d #(.Felements(3), .Out_elements(10)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .ImagesIn  (ins_b),
    .ImagesOut (out_b),
    .valid     (valid_b),
    .busy      (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hand-computed quarter() results for every value the bench drives
  function automatic logic [31:0] exp_q(input logic [31:0] x);
    case (x)
      32'h3F800000: exp_q = 32'h3E800000;
      32'h40800000: exp_q = 32'h3F800000;
      32'hC1000000: exp_q = 32'hC0000000;
      32'h40000000: exp_q = 32'h3F000000;
      32'h01000000: exp_q = 32'h00000000;
      32'h81000000: exp_q = 32'h80000000;
      32'h7F800000: exp_q = 32'h7F800000;
      32'h7FC00000: exp_q = 32'h7FC00000;
      32'h00000000: exp_q = 32'h00000000;
      default:      exp_q = 32'hDEADBEEF;
    endcase
  endfunction

  // Counts edges until the selected valid is seen (sampled 1 unit after the edge), bounded by limit
  task automatic wait_valid(input bit sel_b, input int limit, output int cnt);
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      if ((sel_b ? valid_b : valid_a) || cnt >= limit) break;
    end
  endtask

  task automatic chk_all_b(input string tag);
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++)
          chk($sformatf("%s[%0d][%0d][%0d]", tag, f, r, c), out_b[f][r][c], exp_q(ref_b[f][r/2][c/2]));
  endtask

  task automatic fill_b(input logic [31:0] v);
    for (int f = 0; f < 3; f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          ins_b[f][r][c] = v;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        ins_a[0][r][c] = 32'h0;
    fill_b(32'h0);
    ref_b = ins_b;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_a", {31'b0, valid_a}, 32'd0);
    chk("rst_busy_a",  {31'b0, busy_a},  32'd0);
    chk("rst_valid_b", {31'b0, valid_b}, 32'd0);
    chk("rst_busy_b",  {31'b0, busy_b},  32'd0);
    chk("rst_out_a",   out_a[0][3][3],   32'h0);
    chk("rst_out_b",   out_b[2][9][9],   32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic scaling on N=4: 1.0 -> 0.25, valid 16 edges after start edge
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        ins_a[0][r][c] = 32'h3F800000;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    chk("a_busy_after_start", {31'b0, busy_a}, 32'd1);
    wait_valid(1'b0, 40, n);
    chk("a_latency", n, 32'd16);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        chk($sformatf("a_out[%0d][%0d]", r, c), out_a[0][r][c], 32'h3E800000);
    @(posedge clk);
    #1;
    chk("a_valid_pulse", {31'b0, valid_a}, 32'd0);
    chk("a_busy_done",   {31'b0, busy_a},  32'd0);

    // Replication and special values on N=10, F=3
    fill_b(32'h40800000);
    ins_b[1][2][3] = 32'hC1000000;
    ins_b[2][0][0] = 32'h01000000;
    ins_b[2][0][1] = 32'h81000000;
    ins_b[2][0][2] = 32'h7F800000;
    ins_b[2][0][3] = 32'h7FC00000;
    ins_b[2][0][4] = 32'h00000000;
    ref_b = ins_b;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    wait_valid(1'b1, 200, n);
    chk("b_latency", n, 32'd100);
    chk("b_rep_46", out_b[1][4][6], 32'hC0000000);
    chk("b_rep_47", out_b[1][4][7], 32'hC0000000);
    chk("b_rep_56", out_b[1][5][6], 32'hC0000000);
    chk("b_rep_57", out_b[1][5][7], 32'hC0000000);
    chk("b_sp_denorm_res", out_b[2][0][1], 32'h00000000);
    chk("b_sp_neg_ftz",    out_b[2][1][2], 32'h80000000);
    chk("b_sp_inf",        out_b[2][0][5], 32'h7F800000);
    chk("b_sp_nan",        out_b[2][1][6], 32'h7FC00000);
    chk("b_sp_zero",       out_b[2][1][9], 32'h00000000);
    chk_all_b("b_rep");
    @(posedge clk);
    #1;
    chk("b_valid_pulse", {31'b0, valid_b}, 32'd0);

    // Input stability: changes and a start pulse 20 cycles into RUN are ignored
    fill_b(32'h40000000);
    ref_b = ins_b;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    fill_b(32'h3F800000);
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    wait_valid(1'b1, 200, n);
    chk("stab_latency", n + 21, 32'd100);
    chk_all_b("stab");

    // Reset mid-frame clears everything asynchronously
    fill_b(32'h40000000);
    @(posedge clk);
    #1;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  {31'b0, busy_b},  32'd0);
    chk("mid_rst_valid", {31'b0, valid_b}, 32'd0);
    chk("mid_rst_out0",  out_b[0][0][0],   32'h0);
    chk("mid_rst_out1",  out_b[1][9][9],   32'h0);
    chk("mid_rst_out2",  out_b[2][4][6],   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fill_b(32'h40800000);
    ref_b = ins_b;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    wait_valid(1'b1, 200, n);
    chk("post_rst_latency", n, 32'd100);
    chk_all_b("post_rst");

    // Back-to-back frames on N=4 with start held high: valid every 17 edges
    start_a = 1'b1;
    @(posedge clk);
    #1;
    wait_valid(1'b0, 40, n);
    chk("b2b_first", n, 32'd16);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b_width%0d", k), {31'b0, valid_a}, 32'd0);
      chk($sformatf("b2b_rebusy%0d", k), {31'b0, busy_a}, 32'd1);
      wait_valid(1'b0, 40, n);
      chk($sformatf("b2b_period%0d", k), n + 1, 32'd17);
    end
    start_a = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
